instr_fetch_unit: RTL

//  Instruction fetch front end of the KGP-RISC core. Owns the PC and fetches one

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// KGP-RISC instruction fetch front end: owns the PC, fetches over req/ack, computes next PC.
// Optional perf counters (retired_cnt, taken_cnt) enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [1:0]         branch,
  input  logic               cond_flag,
  input  logic [OFF_W-1:0]   br_offset,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  link_addr,
  input  logic               halt
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        taken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;

  logic [ADDR_W-1:0]   off_ext;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   pc_tgt;
  logic [ADDR_W-1:0]   next_pc;
  logic                retire;

  // Offset is in words: sign-extend, then scale to bytes; sums wrap modulo 2^ADDR_W.
  always_comb begin
    off_ext = {{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    pc_inc  = pc_q + ADDR_W'(4);
    pc_tgt  = pc_inc + (off_ext << 2);
    next_pc = pc_inc;
    case (branch)
      2'b00:   next_pc = pc_inc;
      2'b01:   next_pc = pc_tgt;
      2'b10:   next_pc = cond_flag ? pc_tgt : pc_inc;
      default: next_pc = pc_tgt;
    endcase
  end

  assign retire = (state_q == S_HOLD) && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_HOLD;
          instr_d = imem_rdata;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = halt ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_A;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: 6];
  assign pc_out      = pc_q;
  assign link_addr   = pc_inc;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_cnt_q, taken_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      taken_cnt_q   <= '0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + 32'd1;
      if (next_pc == pc_tgt) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign taken_cnt   = taken_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
